pl_ctrl_issue: RTL

- ID→EX control issue stage of the pipelined core.
- Receives the decoded control bundle (ResultSrc, MemWrite, ALUSrc, ImmSrc, RegWrite, ALUop) plus register indices from the decode stage.
- Registers the bundle into EX, detects load-use hazards and inserts bubbles, applies branch/jump flushes, and produces registered forwarding selects.
- Tracks shadow rd/RegWrite records for the EX, MEM and WB positions so hazard and forwarding decisions stay local to this block.

---
 rtl/pl_ctrl_issue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pl_ctrl_issue.sv
// ID->EX control issue stage: registers the decoded control bundle, inserts
// load-use bubbles, applies flushes and produces registered forwarding selects.
module pl_ctrl_issue #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [1:0]       id_result_src,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic [2:0]       id_imm_src,
  input  logic             id_reg_write,
  input  logic [2:0]       id_alu_op,
  input  logic             flush,
  input  logic             mem_stall,
  output logic             stall,
  output logic             ex_valid,
  output logic [4:0]       ex_rd,
  output logic [1:0]       ex_result_src,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic [2:0]       ex_imm_src,
  output logic             ex_reg_write,
  output logic [2:0]       ex_alu_op,
  output logic [1:0]       ex_fwd_a,
  output logic [1:0]       ex_fwd_b,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
  } shadow_t;

  shadow_t    ex_sh, mem_sh, wb_sh;
  logic       hazard;
  logic       load_bubble;
  logic [1:0] fwd_a_d, fwd_b_d;

  // The WB record completes the in-flight picture; nothing downstream reads it yet.
  logic unused_wb;
  assign unused_wb = ^wb_sh;

  // An older producer forwards only if it writes a nonzero rd that this source reads.
  // The EX position is checked first so the youngest producer wins.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic uses,
                                         input shadow_t ex_r, input shadow_t mem_r);
    logic [1:0] sel;
    sel = FWD_RF;
    if (uses && ex_r.valid && ex_r.reg_write && ex_r.rd != 5'd0 && ex_r.rd == rs)
      sel = FWD_MEM;
    else if (uses && mem_r.valid && mem_r.reg_write && mem_r.rd != 5'd0 && mem_r.rd == rs)
      sel = FWD_WB;
    return sel;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ex_sh       = '{valid: ex_valid, rd: ex_rd, reg_write: ex_reg_write};
    hazard      = 1'b0;
    if (id_valid && ex_valid && ex_result_src == RES_LOAD && ex_rd != 5'd0)
      hazard = (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
    // A killed instruction is never held, so flush masks the hazard stall.
    stall       = mem_stall | (hazard & ~flush);
    load_bubble = flush | hazard | ~id_valid;
    fwd_a_d     = fwd_sel(id_rs1, id_uses_rs1, ex_sh, mem_sh);
    fwd_b_d     = fwd_sel(id_rs2, id_uses_rs2, ex_sh, mem_sh);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which the forwarding and shadow shift rely on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_rd         <= '0;
      ex_result_src <= '0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_imm_src    <= '0;
      ex_reg_write  <= 1'b0;
      ex_alu_op     <= '0;
      ex_fwd_a      <= FWD_RF;
      ex_fwd_b      <= FWD_RF;
      bubble_cnt    <= '0;
      mem_sh        <= '0;
      wb_sh         <= '0;
    end else if (!mem_stall) begin
      wb_sh  <= mem_sh;
      mem_sh <= ex_sh;
      if (hazard && !flush)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (load_bubble) begin
        ex_valid      <= 1'b0;
        ex_rd         <= '0;
        ex_result_src <= '0;
        ex_mem_write  <= 1'b0;
        ex_alu_src    <= 1'b0;
        ex_imm_src    <= '0;
        ex_reg_write  <= 1'b0;
        ex_alu_op     <= '0;
        ex_fwd_a      <= FWD_RF;
        ex_fwd_b      <= FWD_RF;
      end else begin
        ex_valid      <= 1'b1;
        ex_rd         <= id_rd;
        ex_result_src <= id_result_src;
        ex_mem_write  <= id_mem_write;
        ex_alu_src    <= id_alu_src;
        ex_imm_src    <= id_imm_src;
        ex_reg_write  <= id_reg_write;
        ex_alu_op     <= id_alu_op;
        ex_fwd_a      <= fwd_a_d;
        ex_fwd_b      <= fwd_b_d;
      end
    end
  end

endmodule
